// File: rtl/dir_ctrl.sv
// rtl/dir_ctrl.sv - debounced push-button direction toggle with step prescaler
module dir_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int STEP_DIV        = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic dir,
  output logic step,
  output logic btn_db
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [15:0]   CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PS_LAST  = PW'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } db_state_t;

  logic          sync1, btn_s;
  db_state_t     state, state_nx;
  logic [15:0]   cnt, cnt_nx;
  logic          db_nx;
  logic          toggle;
  logic [PW-1:0] ps;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btn;
      btn_s <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE_LO;
      cnt    <= 16'd0;
      btn_db <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      btn_db <= db_nx;
    end
  end

  // Any bounce back to the idle level drops to IDLE_* and restarts the window.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    db_nx    = btn_db;
    case (state)
      IDLE_LO: begin
        if (btn_s) begin
          state_nx = WAIT_HI;
          cnt_nx   = 16'd0;
        end
      end
      WAIT_HI: begin
        if (!btn_s) begin
          state_nx = IDLE_LO;
        end else if (cnt == CNT_LAST) begin
          state_nx = IDLE_HI;
          db_nx    = 1'b1;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      IDLE_HI: begin
        if (!btn_s) begin
          state_nx = WAIT_LO;
          cnt_nx   = 16'd0;
        end
      end
      WAIT_LO: begin
        if (btn_s) begin
          state_nx = IDLE_HI;
        end else if (cnt == CNT_LAST) begin
          state_nx = IDLE_LO;
          db_nx    = 1'b0;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      default: begin
        state_nx = IDLE_LO;
        cnt_nx   = 16'd0;
        db_nx    = 1'b0;
      end
    endcase
  end

  assign toggle = db_nx & ~btn_db;

  // A direction change restarts the step period and suppresses a coincident pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir  <= 1'b1;
      ps   <= '0;
      step <= 1'b0;
    end else begin
      dir <= dir ^ toggle;
      if (toggle) begin
        ps   <= '0;
        step <= 1'b0;
      end else if (ps == PS_LAST) begin
        ps   <= '0;
        step <= 1'b1;
      end else begin
        ps   <= ps + 1'b1;
        step <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dir_ctrl.sv
// tb/tb_dir_ctrl.sv - directed self-checking bench for dir_ctrl (DEBOUNCE_CYCLES=4, STEP_DIV=8)
module tb_dir_ctrl;

  logic clk, rst, btn;
  logic dir, step, btn_db;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   edge_n  = 0;
  int   toggles, last_tog, min_gap;
  logic prev_dir;

  dir_ctrl #(.DEBOUNCE_CYCLES(4), .STEP_DIV(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .dir   (dir),
    .step  (step),
    .btn_db(btn_db)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    btn = 1'b0;
    #1;
    chk("rst_dir", 32'(dir), 32'd1);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_db", 32'(btn_db), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    rst = 1'b0;
    btn = 1'b0;

    // Idle after reset: steps on 8, 16, 24
    do_reset();
    for (int i = 1; i <= 24; i++) begin
      tick();
      chk("A_step", 32'(step), 32'((edge_n % 8) == 0));
    end
    chk("A_dir", 32'(dir), 32'd1);
    chk("A_db", 32'(btn_db), 32'd0);

    // Press sampled on edge 10: toggle on 16 collides with a wrap
    do_reset();
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk("B_step", 32'(step), 32'(edge_n == 8 || edge_n == 24 || edge_n == 32));
      chk("B_db", 32'(btn_db), 32'(edge_n >= 16));
      chk("B_dir", 32'(dir), 32'(edge_n < 16));
      if (edge_n == 9) btn = 1'b1;
    end
    btn = 1'b0;
    for (int i = 33; i <= 40; i++) begin
      tick();
      chk("B_rel_db", 32'(btn_db), 32'(edge_n < 39));
      chk("B_rel_dir", 32'(dir), 32'd0);
      chk("B_rel_step", 32'(step), 32'(edge_n == 40));
    end
    btn = 1'b1;
    for (int i = 41; i <= 56; i++) begin
      tick();
      chk("B_re_dir", 32'(dir), 32'(edge_n >= 47));
      chk("B_re_step", 32'(step), 32'(edge_n == 55));
    end

    // Ten more full presses
    btn = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    toggles  = 0;
    last_tog = -100;
    min_gap  = 1000;
    prev_dir = dir;
    for (int p = 0; p < 10; p++) begin
      for (int h = 0; h < 16; h++) begin
        btn = (h < 8);
        tick();
        if (dir !== prev_dir) begin
          toggles++;
          if (edge_n - last_tog < min_gap) min_gap = edge_n - last_tog;
          last_tog = edge_n;
        end
        prev_dir = dir;
      end
    end
    chk("P_toggles", 32'(toggles), 32'd10);
    chk("P_dir", 32'(dir), 32'd1);
    chk("P_gap_ok", 32'(min_gap >= 4), 32'd1);

    // Press sampled on edge 11: toggle on 17, next step on 25
    do_reset();
    for (int i = 1; i <= 28; i++) begin
      tick();
      chk("C_step", 32'(step), 32'(edge_n == 8 || edge_n == 16 || edge_n == 25));
      chk("C_dir", 32'(dir), 32'(edge_n < 17));
      if (edge_n == 10) btn = 1'b1;
    end

    // Bounce: runs of 2 high / 2 low for 20 cycles, then low
    do_reset();
    for (int i = 1; i <= 32; i++) begin
      btn = (edge_n < 20) ? (((edge_n / 2) % 2) == 0) : 1'b0;
      tick();
      chk("D_db", 32'(btn_db), 32'd0);
      chk("D_dir", 32'(dir), 32'd1);
      chk("D_step", 32'(step), 32'((edge_n % 8) == 0));
    end

    // Reset asserted mid-debounce with dir=0
    do_reset();
    btn = 1'b1;
    for (int i = 1; i <= 7; i++) tick();
    chk("E_dir0", 32'(dir), 32'd0);
    btn = 1'b0;
    for (int i = 8; i <= 20; i++) tick();
    chk("E_db0", 32'(btn_db), 32'd0);
    btn = 1'b1;
    for (int i = 21; i <= 24; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("E_async_dir", 32'(dir), 32'd1);
    chk("E_async_step", 32'(step), 32'd0);
    chk("E_async_db", 32'(btn_db), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    edge_n = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("E_db", 32'(btn_db), 32'(edge_n >= 7));
      chk("E_dir", 32'(dir), 32'(edge_n < 7));
      chk("E_step", 32'(step), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
